// File: rtl/loader_defs.sv
// rtl/loader_defs.sv - shared state encoding and frame-layout constants for the program loader
package loader_defs;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT_HI,
    ST_COUNT_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CHECKSUM
  } state_t;

  localparam logic [7:0] DEFAULT_START_BYTE     = 8'h4C;
  localparam int         DEFAULT_TIMEOUT_CYCLES = 12_000_000;
  localparam int         TIMEOUT_WIDTH          = 24;
  localparam int         COUNT_WIDTH            = 16;

  // Largest word count a memory of 2^aw words can accept; one bit wider than the count field.
  function automatic logic [COUNT_WIDTH:0] max_words(input int aw);
    logic [COUNT_WIDTH:0] r;
    r = {{COUNT_WIDTH{1'b0}}, 1'b1} << aw;
    return r;
  endfunction

endpackage

// File: rtl/byte_timeout.sv
// rtl/byte_timeout.sv - inter-byte idle counter with clear, enable and expired flag
module byte_timeout
  import loader_defs::*;
#(
  parameter int WIDTH = TIMEOUT_WIDTH,
  parameter int LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Holds at LAST so a late expiry is still reported until the owner reacts.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - UART frame to program RAM loader with checksum and CPU halt control
module program_loader
  import loader_defs::*;
#(
  parameter int         ADDRESS_WIDTH  = 10,
  parameter logic [7:0] START_BYTE     = DEFAULT_START_BYTE,
  parameter int         TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [15:0]              mem_data,
  output logic                     mem_write_enable,
  output logic                     cpu_halt,
  output logic                     load_done,
  output logic                     load_error
);

  localparam logic [COUNT_WIDTH:0] MAX_WORDS = max_words(ADDRESS_WIDTH);

  state_t                   state_q, state_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic [COUNT_WIDTH-1:0]   index_q, index_d;
  logic [7:0]               sum_q, sum_d;
  logic [7:0]               hi_q, hi_d;
  logic [ADDRESS_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [15:0]              mem_data_q, mem_data_d;
  logic                     mem_write_enable_q, mem_write_enable_d;
  logic                     cpu_halt_q, cpu_halt_d;
  logic                     load_done_q, load_done_d;
  logic                     load_error_q, load_error_d;

  logic [COUNT_WIDTH-1:0]   count_full;
  logic [COUNT_WIDTH-1:0]   index_next;
  logic                     in_frame;
  logic                     timeout_expired;
  logic                     timeout_hit;

  assign in_frame   = (state_q != ST_IDLE);
  assign count_full = {count_q[15:8], rx_data};
  assign index_next = index_q + 1'b1;

  byte_timeout #(
    .WIDTH (TIMEOUT_WIDTH),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_byte_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (rx_valid || !in_frame),
    .enable  (in_frame),
    .expired (timeout_expired)
  );

  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign timeout_hit = timeout_expired && !rx_valid;

  always_comb begin
    state_d            = state_q;
    count_d            = count_q;
    index_d            = index_q;
    sum_d              = sum_q;
    hi_d               = hi_q;
    mem_address_d      = mem_address_q;
    mem_data_d         = mem_data_q;
    mem_write_enable_d = 1'b0;
    cpu_halt_d         = cpu_halt_q;
    load_done_d        = 1'b0;
    load_error_d       = load_error_q;

    if (timeout_hit) begin
      load_error_d = 1'b1;
      state_d      = ST_IDLE;
    end else if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == START_BYTE) begin
            state_d      = ST_COUNT_HI;
            cpu_halt_d   = 1'b1;
            load_error_d = 1'b0;
            index_d      = '0;
            sum_d        = '0;
          end
        end
        ST_COUNT_HI: begin
          count_d = {rx_data, 8'h00};
          state_d = ST_COUNT_LO;
        end
        ST_COUNT_LO: begin
          count_d = count_full;
          if (count_full == '0) begin
            state_d = ST_CHECKSUM;
          end else if ({1'b0, count_full} > MAX_WORDS) begin
            load_error_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_DATA_HI;
          end
        end
        ST_DATA_HI: begin
          hi_d    = rx_data;
          sum_d   = sum_q + rx_data;
          state_d = ST_DATA_LO;
        end
        ST_DATA_LO: begin
          sum_d              = sum_q + rx_data;
          mem_write_enable_d = 1'b1;
          mem_address_d      = index_q[ADDRESS_WIDTH-1:0];
          mem_data_d         = {hi_q, rx_data};
          index_d            = index_next;
          state_d            = (index_next == count_q) ? ST_CHECKSUM : ST_DATA_HI;
        end
        ST_CHECKSUM: begin
          if (rx_data == sum_q) begin
            load_done_d = 1'b1;
            cpu_halt_d  = 1'b0;
          end else begin
            load_error_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= ST_IDLE;
      count_q            <= '0;
      index_q            <= '0;
      sum_q              <= '0;
      hi_q               <= '0;
      mem_address_q      <= '0;
      mem_data_q         <= '0;
      mem_write_enable_q <= 1'b0;
      cpu_halt_q         <= 1'b0;
      load_done_q        <= 1'b0;
      load_error_q       <= 1'b0;
    end else begin
      state_q            <= state_d;
      count_q            <= count_d;
      index_q            <= index_d;
      sum_q              <= sum_d;
      hi_q               <= hi_d;
      mem_address_q      <= mem_address_d;
      mem_data_q         <= mem_data_d;
      mem_write_enable_q <= mem_write_enable_d;
      cpu_halt_q         <= cpu_halt_d;
      load_done_q        <= load_done_d;
      load_error_q       <= load_error_d;
    end
  end

  assign mem_address      = mem_address_q;
  assign mem_data         = mem_data_q;
  assign mem_write_enable = mem_write_enable_q;
  assign cpu_halt         = cpu_halt_q;
  assign load_done        = load_done_q;
  assign load_error       = load_error_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader against a frame-position model
module tb_program_loader;

  localparam int AW = 10;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic [AW-1:0] mem_address;
  logic [15:0]   mem_data;
  logic          mem_write_enable;
  logic          cpu_halt;
  logic          load_done;
  logic          load_error;

  always #5 clk = ~clk;

  program_loader #(
    .ADDRESS_WIDTH  (AW),
    .START_BYTE     (8'h4C),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .mem_address      (mem_address),
    .mem_data         (mem_data),
    .mem_write_enable (mem_write_enable),
    .cpu_halt         (cpu_halt),
    .load_done        (load_done),
    .load_error       (load_error)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Model: tracks position within the frame and derives outputs from the frame rules.
  int            cyc = 0;
  bit            m_in_frame = 0;
  int            m_pos, m_cnt, m_sum, m_idle;
  logic [7:0]    m_hi;
  logic          exp_we = 0, exp_halt = 0, exp_done = 0, exp_err = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [15:0]   exp_data = '0;
  int            last_rx_cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_in_frame = 0; m_idle = 0;
      exp_we = 0; exp_halt = 0; exp_done = 0; exp_err = 0;
      exp_addr = '0; exp_data = '0;
    end else begin
      exp_we = 0;
      exp_done = 0;
      if (rx_valid) last_rx_cyc = cyc;
      if (!m_in_frame) begin
        m_idle = 0;
        if (rx_valid && rx_data == 8'h4C) begin
          m_in_frame = 1; m_pos = 0; m_sum = 0;
          exp_halt = 1; exp_err = 0;
        end
      end else if (rx_valid) begin
        m_idle = 0;
        m_pos++;
        if (m_pos == 1) begin
          m_cnt = int'(rx_data) * 256;
        end else if (m_pos == 2) begin
          m_cnt += int'(rx_data);
          if (m_cnt > (1 << AW)) begin
            exp_err = 1; m_in_frame = 0;
          end
        end else if (m_pos <= 2 + 2 * m_cnt) begin
          m_sum += int'(rx_data);
          if (m_pos % 2 == 1) begin
            m_hi = rx_data;
          end else begin
            exp_we = 1;
            exp_addr = AW'((m_pos - 4) / 2);
            exp_data = {m_hi, rx_data};
          end
        end else begin
          if (int'(rx_data) == (m_sum % 256)) begin
            exp_done = 1; exp_halt = 0;
          end else begin
            exp_err = 1;
          end
          m_in_frame = 0;
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          exp_err = 1; m_in_frame = 0; m_idle = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("cmp_mem_write_enable", 32'(mem_write_enable), 32'(exp_we));
      check("cmp_mem_address", 32'(mem_address), 32'(exp_addr));
      check("cmp_mem_data", 32'(mem_data), 32'(exp_data));
      check("cmp_cpu_halt", 32'(cpu_halt), 32'(exp_halt));
      check("cmp_load_done", 32'(load_done), 32'(exp_done));
      check("cmp_load_error", 32'(load_error), 32'(exp_err));
    end
  end

  // Observed-behaviour log for the literal expectations.
  int          w_addr[$];
  int          w_data[$];
  int          w_cyc[$];
  int          done_cnt = 0;
  int          err_rise_cyc = -1;
  logic        err_prev = 1'b0;

  always @(negedge clk) begin
    if (mem_write_enable) begin
      w_addr.push_back(int'(mem_address));
      w_data.push_back(int'(mem_data));
      w_cyc.push_back(cyc);
    end
    if (load_done) done_cnt++;
    if (load_error && !err_prev) err_rise_cyc = cyc;
    err_prev = load_error;
  end

  task automatic clear_log();
    w_addr.delete(); w_data.delete(); w_cyc.delete();
    done_cnt = 0;
    err_rise_cyc = -1;
  endtask

  task automatic put(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk); #2;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #2; end
  endtask

  task automatic frame(input logic [127:0] bytes, input int n, input int gap);
    for (int k = 0; k < n; k++) put(bytes[8*(n-1-k) +: 8], gap);
  endtask

  task automatic settle();
    repeat (3) begin @(posedge clk); #2; end
  endtask

  task automatic check_three_words(input string tag);
    check({tag, "_write_count"}, 32'(w_addr.size()), 32'd3);
    if (w_addr.size() == 3) begin
      check({tag, "_addr0"}, 32'(w_addr[0]), 32'd0);
      check({tag, "_data0"}, 32'(w_data[0]), 32'h1234);
      check({tag, "_addr1"}, 32'(w_addr[1]), 32'd1);
      check({tag, "_data1"}, 32'(w_data[1]), 32'h5678);
      check({tag, "_addr2"}, 32'(w_addr[2]), 32'd2);
      check({tag, "_data2"}, 32'(w_data[2]), 32'h9ABC);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("reset_halt", 32'(cpu_halt), 32'd0);
    check("reset_we", 32'(mem_write_enable), 32'd0);
    check("reset_addr_data", {6'd0, mem_address, mem_data}, 32'd0);
    check("reset_done_err", {30'd0, load_done, load_error}, 32'd0);
    @(posedge clk); #2;

    // Noise in IDLE.
    clear_log();
    put(8'h00, 1); put(8'hFF, 1);
    settle();
    check("noise_halt", 32'(cpu_halt), 32'd0);
    check("noise_writes", 32'(w_addr.size()), 32'd0);

    // Good 3-word image; data sum 0x26A -> checksum 0x6A.
    clear_log();
    frame(128'h4C0003123456789ABC6A, 10, 1);
    settle();
    check_three_words("good");
    check("good_done", 32'(done_cnt), 32'd1);
    check("good_halt", 32'(cpu_halt), 32'd0);
    check("good_err", 32'(load_error), 32'd0);

    // Bad checksum: words still written, error sticky, CPU held.
    clear_log();
    frame(128'h4C0003123456789ABC69, 10, 1);
    settle();
    check_three_words("bad");
    check("bad_done", 32'(done_cnt), 32'd0);
    check("bad_err", 32'(load_error), 32'd1);
    check("bad_halt", 32'(cpu_halt), 32'd1);

    clear_log();
    frame(128'h4C0003123456789ABC6A, 10, 1);
    settle();
    check("recover_err", 32'(load_error), 32'd0);
    check("recover_halt", 32'(cpu_halt), 32'd0);
    check("recover_done", 32'(done_cnt), 32'd1);

    // Count one above capacity.
    clear_log();
    frame(128'h4C0401, 3, 1);
    settle();
    check("oversize_err", 32'(load_error), 32'd1);
    check("oversize_halt", 32'(cpu_halt), 32'd1);
    check("oversize_writes", 32'(w_addr.size()), 32'd0);

    // Empty image.
    clear_log();
    frame(128'h4C000000, 4, 1);
    settle();
    check("empty_done", 32'(done_cnt), 32'd1);
    check("empty_writes", 32'(w_addr.size()), 32'd0);
    check("empty_halt", 32'(cpu_halt), 32'd0);

    // Stream stalls mid-frame.
    clear_log();
    frame(128'h4C0002AA, 4, 0);
    for (int i = 0; i < 40 && err_rise_cyc < 0; i++) @(posedge clk);
    #2;
    check("timeout_delay", 32'(err_rise_cyc - last_rx_cyc), 32'd16);
    check("timeout_halt", 32'(cpu_halt), 32'd1);
    check("timeout_writes", 32'(w_addr.size()), 32'd0);
    settle();

    // A byte landing on the expiry cycle wins; frame completes.
    clear_log();
    put(8'h4C, 1); put(8'h00, 1); put(8'h01, 1);
    put(8'h11, 15);
    put(8'h22, 1); put(8'h33, 1);
    settle();
    check("late_byte_done", 32'(done_cnt), 32'd1);
    check("late_byte_err", 32'(load_error), 32'd0);
    check("late_byte_writes", 32'(w_addr.size()), 32'd1);
    if (w_data.size() == 1) check("late_byte_data", 32'(w_data[0]), 32'h1122);

    // Reset during the low byte of word 1.
    clear_log();
    frame(128'h4C0003123456, 6, 1);
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    check("midreset_halt", 32'(cpu_halt), 32'd0);
    check("midreset_data", 32'(mem_data), 32'd0);
    check("midreset_we", 32'(mem_write_enable), 32'd0);
    @(posedge clk); #2;

    // Back-to-back full frame after reset.
    clear_log();
    frame(128'h4C0003123456789ABC6A, 10, 0);
    settle();
    check_three_words("b2b");
    check("b2b_done", 32'(done_cnt), 32'd1);
    if (w_cyc.size() == 3) begin
      check("b2b_spacing01", 32'(w_cyc[1] - w_cyc[0]), 32'd2);
      check("b2b_spacing12", 32'(w_cyc[2] - w_cyc[1]), 32'd2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
